// File: rtl/sd_dma_pkg.sv
// Shared Wishbone cycle-type constants and FSM encoding for the SD DMA masters.
package sd_dma_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_XFER,
    ST_ERR
  } dma_state_e;

endpackage

// File: rtl/sd_rx_dma_burst.sv
// Wishbone B3 burst master draining the SD RX FIFO into memory.
// Define SD_RX_DMA_BYTE_SWAP_EN to byte-reverse each word on its way to the bus.
module sd_rx_dma_burst
  import sd_dma_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 16,
  parameter int LVL_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  words_done_o,
  input  logic [DW-1:0]     fifo_dat_i,
  input  logic              fifo_empty_i,
  input  logic [LVL_W-1:0]  fifo_level_i,
  output logic              fifo_rd_o,
  output logic [AW-1:0]     m_wb_adr_o,
  output logic [DW-1:0]     m_wb_dat_o,
  output logic [DW/8-1:0]   m_wb_sel_o,
  output logic              m_wb_we_o,
  output logic              m_wb_cyc_o,
  output logic              m_wb_stb_o,
  output logic [2:0]        m_wb_cti_o,
  output logic [1:0]        m_wb_bte_o,
  input  logic              m_wb_ack_i,
  input  logic              m_wb_err_i
);

  localparam int                 SW          = DW / 8;
  localparam int                 BEAT_W      = $clog2(BURST_LEN) + 1;
  localparam logic [AW-1:0]      STEP        = AW'(SW);
  localparam logic [LEN_W-1:0]   BURST_REM   = LEN_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]   BURST_LVL   = LVL_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]  BEATS_FULL  = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0]  BEATS_ONE   = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]  BEATS_TWO   = BEAT_W'(2);
  localparam logic [LEN_W-1:0]   REM_ONE     = LEN_W'(1);

  dma_state_e         state_q, state_d;
  logic [AW-1:0]      base_q, base_d;
  logic [AW-1:0]      offset_q, offset_d;
  logic [AW-1:0]      adr_q;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic               burst_q, burst_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic [2:0]         cti_q, cti_d;
  logic               cyc_q, cyc_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [DW-1:0]      load_word;

  always_comb begin
    load_word = fifo_dat_i;
`ifdef SD_RX_DMA_BYTE_SWAP_EN
    for (int i = 0; i < SW; i++) begin
      load_word[8*i +: 8] = fifo_dat_i[DW-8-8*i +: 8];
    end
`endif
  end

  // NOTE: every signal driven here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    offset_d  = offset_q;
    rem_d     = rem_q;
    words_d   = words_q;
    beats_d   = beats_q;
    burst_d   = burst_q;
    dat_d     = dat_q;
    cti_d     = cti_q;
    cyc_d     = cyc_q;
    err_d     = err_q;
    done_d    = 1'b0;
    fifo_rd_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && en_i) begin
          base_d   = adr_i;
          rem_d    = len_i;
          offset_d = '0;
          words_d  = '0;
          err_d    = 1'b0;
          if (len_i == '0) done_d  = 1'b1;
          else             state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (rem_q >= BURST_REM && fifo_level_i >= BURST_LVL) begin
          beats_d = BEATS_FULL;
          burst_d = 1'b1;
          state_d = ST_LOAD;
        end else if (!fifo_empty_i) begin
          beats_d = BEATS_ONE;
          burst_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else begin
          fifo_rd_o = ~fifo_empty_i;
          dat_d     = load_word;
          cyc_d     = 1'b1;
          cti_d     = !burst_q ? CTI_CLASSIC : (beats_q == BEATS_ONE ? CTI_EOB : CTI_INCR);
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        // An error beat is never counted, even when acked in the same cycle.
        if (m_wb_err_i) begin
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          err_d   = 1'b1;
          state_d = en_i ? ST_ERR : ST_IDLE;
        end else begin
          if (m_wb_ack_i) begin
            offset_d = offset_q + STEP;
            rem_d    = rem_q - REM_ONE;
            words_d  = words_q + REM_ONE;
            beats_d  = beats_q - BEATS_ONE;
            if (beats_q > BEATS_ONE) begin
              if (en_i) begin
                fifo_rd_o = ~fifo_empty_i;
                dat_d     = load_word;
                if (burst_q && beats_q == BEATS_TWO) cti_d = CTI_EOB;
              end
            end else begin
              cyc_d = 1'b0;
              cti_d = CTI_CLASSIC;
              if (rem_q == REM_ONE) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end
          // Abort overrides completion: the acked beat stays counted but done is suppressed.
          if (!en_i) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            done_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (!en_i || start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      offset_q <= '0;
      adr_q    <= '0;
      rem_q    <= '0;
      words_q  <= '0;
      beats_q  <= '0;
      burst_q  <= 1'b0;
      dat_q    <= '0;
      cti_q    <= CTI_CLASSIC;
      cyc_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      adr_q    <= base_d + offset_d;
      rem_q    <= rem_d;
      words_q  <= words_d;
      beats_q  <= beats_d;
      burst_q  <= burst_d;
      dat_q    <= dat_d;
      cti_q    <= cti_d;
      cyc_q    <= cyc_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = words_q;
  assign m_wb_adr_o   = adr_q;
  assign m_wb_dat_o   = dat_q;
  assign m_wb_sel_o   = '1;
  assign m_wb_we_o    = cyc_q;
  assign m_wb_cyc_o   = cyc_q;
  assign m_wb_stb_o   = cyc_q;
  assign m_wb_cti_o   = cti_q;
  assign m_wb_bte_o   = BTE_LINEAR;

endmodule

// File: tb/tb_sd_rx_dma_burst.sv
// Scoreboard bench for sd_rx_dma_burst: FIFO model, Wishbone slave model, expected-beat queue.
module tb_sd_rx_dma_burst;

  localparam int BL = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  logic        clk, rst;
  logic        start_i, en_i;
  logic [31:0] adr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_done_o;
  logic [31:0] fifo_dat_i;
  logic        fifo_empty_i;
  logic [4:0]  fifo_level_i;
  logic        fifo_rd_o;
  logic [31:0] m_wb_adr_o, m_wb_dat_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;
  logic        m_wb_ack_i, m_wb_err_i;

  int total = 0;
  int bad = 0;
  int resp_cnt, err_at, ack_limit;
  int pop_cnt = 0, done_cnt = 0;
  int pop0, done0;
  logic pop_pend = 1'b0;
  beat_t exp_q[$];
  beat_t mon_e;
  logic [31:0] fifo_q[$];

  sd_rx_dma_burst #(
    .DW(32), .AW(32), .BURST_LEN(BL), .LEN_W(16), .LVL_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .en_i(en_i), .adr_i(adr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_done_o(words_done_o),
    .fifo_dat_i(fifo_dat_i), .fifo_empty_i(fifo_empty_i), .fifo_level_i(fifo_level_i),
    .fifo_rd_o(fifo_rd_o), .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o),
    .m_wb_stb_o(m_wb_stb_o), .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] w);
`ifdef SD_RX_DMA_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] word_val(input int t, input int i);
    if (t == 1 && i == 0) return 32'h1122_3344;
    return 32'hA500_0000 | (32'(t) << 16) | 32'(i);
  endfunction

  task automatic refresh();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_dat_i   = fifo_empty_i ? 32'h0 : fifo_q[0];
    fifo_level_i = (fifo_q.size() > 31) ? 5'd31 : 5'(fifo_q.size());
  endtask

  // FIFO model: pops seen at a rising edge are applied on the following falling edge.
  always @(posedge clk) begin
    pop_pend <= fifo_rd_o;
    check("rd_on_empty", fifo_rd_o & fifo_empty_i, 0);
  end

  always @(negedge clk) begin
    if (pop_pend) begin
      if (fifo_q.size() > 0) fifo_q.delete(0);
      pop_cnt++;
      refresh();
    end
  end

  // Wishbone slave and scoreboard consumer.
  always @(negedge clk) begin
    m_wb_ack_i = 1'b0;
    m_wb_err_i = 1'b0;
    if (rst && m_wb_cyc_o && m_wb_stb_o) begin
      if (resp_cnt == err_at)        m_wb_err_i = 1'b1;
      else if (resp_cnt < ack_limit) m_wb_ack_i = 1'b1;
      if (m_wb_ack_i || m_wb_err_i) begin
        resp_cnt++;
        check("sb_unexpected", exp_q.size() == 0, 0);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("wb_adr", m_wb_adr_o, mon_e.adr);
          check("wb_dat", m_wb_dat_o, mon_e.dat);
          check("wb_cti", m_wb_cti_o, mon_e.cti);
          check("wb_we_sel", {m_wb_we_o, m_wb_sel_o, m_wb_bte_o}, {1'b1, 4'hF, 2'b00});
        end
      end
    end
    if (rst && done_o) done_cnt++;
  end

  task automatic plan(input logic [31:0] adr, input int len, input int t);
    int rem;
    int idx;
    beat_t e;
    rem = len;
    idx = 0;
    while (rem > 0) begin
      int b;
      b = (rem >= BL) ? BL : 1;
      for (int k = 0; k < b; k++) begin
        e.adr = adr + 32'(4 * idx);
        e.dat = exp_data(word_val(t, idx));
        e.cti = (b == 1) ? 3'b000 : ((k == b - 1) ? 3'b111 : 3'b010);
        exp_q.push_back(e);
        idx++;
      end
      rem -= b;
    end
  endtask

  task automatic begin_test(input int t, input int preload);
    @(posedge clk);
    #2;
    resp_cnt  = 0;
    err_at    = -1;
    ack_limit = 1 << 30;
    exp_q.delete();
    fifo_q.delete();
    for (int i = 0; i < preload; i++) fifo_q.push_back(word_val(t, i));
    refresh();
    pop0  = pop_cnt;
    done0 = done_cnt;
  endtask

  task automatic start_xfer(input logic [31:0] adr, input logic [15:0] len);
    @(negedge clk);
    adr_i   = adr;
    len_i   = len;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy_o && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_o, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus"}, {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_cti_o, m_wb_bte_o}, 0);
    check({tag, "_adr"}, m_wb_adr_o, 0);
    check({tag, "_dat"}, m_wb_dat_o, 0);
    check({tag, "_sel"}, m_wb_sel_o, 4'hF);
    check({tag, "_stat"}, {busy_o, done_o, err_o, fifo_rd_o}, 0);
    check({tag, "_words"}, words_done_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    rst = 1'b1; start_i = 1'b0; en_i = 1'b0; adr_i = '0; len_i = '0;
    m_wb_ack_i = 1'b0; m_wb_err_i = 1'b0;
    resp_cnt = 0; err_at = -1; ack_limit = 1 << 30;
    refresh();
    #3 rst = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clk); #2 rst = 1'b1;
    en_i = 1'b1;

    // len = 0 completes immediately without leaving IDLE
    begin_test(0, 0);
    start_xfer(32'h6000, 16'd0);
    check("len0_done", done_o, 1);
    check("len0_busy", busy_o, 0);
    @(negedge clk);
    check("len0_pulse", done_o, 0);

    // two back-to-back 4-beat bursts
    begin_test(1, 8);
    plan(32'h1000, 8, 1);
    start_xfer(32'h1000, 16'd8);
    check("t1_busy", busy_o, 1);
    wait_idle("t1_idle", 200);
    check("t1_done", done_cnt - done0, 1);
    check("t1_words", words_done_o, 8);
    check("t1_pops", pop_cnt - pop0, 8);
    check("t1_sb_left", exp_q.size(), 0);

    // trickle-fed FIFO gives single beats
    begin_test(2, 0);
    plan(32'h2000, 3, 2);
    start_xfer(32'h2000, 16'd3);
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(posedge clk);
      #2;
      fifo_q.push_back(word_val(2, i));
      refresh();
    end
    wait_idle("t2_idle", 100);
    check("t2_done", done_cnt - done0, 1);
    check("t2_words", words_done_o, 3);
    check("t2_sb_left", exp_q.size(), 0);

    // burst followed by singles once rem < BURST_LEN
    begin_test(3, 6);
    plan(32'h2800, 6, 3);
    start_xfer(32'h2800, 16'd6);
    wait_idle("t3_idle", 200);
    check("t3_done", done_cnt - done0, 1);
    check("t3_words", words_done_o, 6);
    check("t3_pops", pop_cnt - pop0, 6);
    check("t3_sb_left", exp_q.size(), 0);

    // bus error on the second beat of a burst
    begin_test(4, 4);
    err_at = 1;
    plan(32'h3000, 4, 4);
    start_xfer(32'h3000, 16'd4);
    n = 0;
    while (!err_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_err", err_o, 1);
    check("t4_cyc", {m_wb_cyc_o, m_wb_stb_o}, 0);
    check("t4_words", words_done_o, 1);
    check("t4_busy", busy_o, 1);
    check("t4_pops", pop_cnt - pop0, 2);
    check("t4_sb_left", exp_q.size(), 2);
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_idle", busy_o, 0);
    check("t4_sticky", err_o, 1);
    check("t4_nodone", done_cnt - done0, 0);
    en_i = 1'b1;
    begin_test(7, 1);
    plan(32'h3100, 1, 7);
    start_xfer(32'h3100, 16'd1);
    check("t4_err_clr", err_o, 0);
    wait_idle("t4b_idle", 100);
    check("t4b_done", done_cnt - done0, 1);
    check("t4b_words", words_done_o, 1);

    // enable dropped mid-burst after two acks
    begin_test(5, 4);
    ack_limit = 2;
    plan(32'h4000, 4, 5);
    start_xfer(32'h4000, 16'd4);
    n = 0;
    while (words_done_o != 16'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_acks", words_done_o, 2);
    en_i = 1'b0;
    @(negedge clk);
    check("t5_cyc", {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 0);
    check("t5_busy", busy_o, 0);
    @(negedge clk);
    check("t5_words", words_done_o, 2);
    check("t5_pops", pop_cnt - pop0, 3);
    check("t5_nodone", done_cnt - done0, 0);
    check("t5_sb_left", exp_q.size(), 2);
    en_i = 1'b1;

    // asynchronous reset in the middle of a burst
    begin_test(6, 8);
    plan(32'h5000, 8, 6);
    start_xfer(32'h5000, 16'd8);
    n = 0;
    while (words_done_o != 16'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_acks", words_done_o, 2);
    #2 rst = 1'b0;
    #1 check_reset_outputs("t6_rst");
    @(posedge clk); #2 rst = 1'b1;

    // recovery after reset
    begin_test(8, 1);
    plan(32'h5800, 1, 8);
    start_xfer(32'h5800, 16'd1);
    wait_idle("t7_idle", 100);
    check("t7_done", done_cnt - done0, 1);
    check("t7_sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
